eco32f_wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone B3 arbiter that shares the single external bus between the instruction-fetch refill master (ibus) and the load/store master (dbus).
- Sits between the fetch/memory stages and the SoC interconnect.
- Holds the grant for a whole cycle (including 8-beat wrapping bursts) and round-robins between contenders.
- A watchdog turns a hung slave into a bus error.

---
 rtl/eco32f_wb_arbiter_pkg.sv | 45 ++++
 rtl/eco32f_wb_watchdog.sv | 31 +++
 rtl/eco32f_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_eco32f_wb_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eco32f_wb_arbiter_pkg.sv
// Shared Wishbone cycle-type constants, arbiter state encoding and request bundle
// for the eco32f two-master bus arbiter.
package eco32f_wb_arbiter_pkg;

  localparam logic [2:0] ECO32F_WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] ECO32F_WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] ECO32F_WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] ECO32F_WB_BTE_WRAP8   = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } arb_mst_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
    logic        stb;
    logic        cyc;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '0;

  // On contention the master that did not own the bus last time wins.
  function automatic arb_state_e arb_pick(input logic i_cyc, input logic d_cyc,
                                          input arb_mst_e last);
    arb_state_e pick;
    pick = ARB_IDLE;
    if (i_cyc && d_cyc) pick = (last == MST_I) ? ARB_GNT_D : ARB_GNT_I;
    else if (i_cyc)     pick = ARB_GNT_I;
    else if (d_cyc)     pick = ARB_GNT_D;
    return pick;
  endfunction

endpackage

// File: rtl/eco32f_wb_watchdog.sv
// Stall watchdog: counts consecutive strobed cycles without a termination and
// fires combinationally in the cycle the count reaches TIMEOUT-1.
module eco32f_wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic fire_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Firing also clears the counter, so it can never pass CNT_LAST and wrap.
  always_comb begin
    fire_o = en_i && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    if (clr_i || fire_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/eco32f_wb_arbiter.sv
// Two-master Wishbone B3 arbiter: registered grant (1 cycle from cyc to slave), grant held
// until the owner drops cyc, round-robin on contention, watchdog turns a hung slave into err.
module eco32f_wb_arbiter
  import eco32f_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ibus_adr_i,
  input  logic        ibus_stb_i,
  input  logic        ibus_cyc_i,
  input  logic        ibus_we_i,
  input  logic [3:0]  ibus_sel_i,
  input  logic [2:0]  ibus_cti_i,
  input  logic [1:0]  ibus_bte_i,
  input  logic [31:0] ibus_dat_i,
  output logic        ibus_ack_o,
  output logic        ibus_err_o,
  output logic        ibus_rty_o,
  output logic [31:0] ibus_dat_o,
  input  logic [31:0] dbus_adr_i,
  input  logic        dbus_stb_i,
  input  logic        dbus_cyc_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_sel_i,
  input  logic [2:0]  dbus_cti_i,
  input  logic [1:0]  dbus_bte_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic        dbus_rty_o,
  output logic [31:0] dbus_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  arb_mst_e   last_q, last_d;
  wb_req_t    ireq, dreq, greq;
  logic       gnt_i, gnt_d, granted, term;
  logic       wd_en, wd_clr, wd_fire;

  assign ireq = '{adr: ibus_adr_i, dat: ibus_dat_i, sel: ibus_sel_i, cti: ibus_cti_i,
                  bte: ibus_bte_i, we: ibus_we_i, stb: ibus_stb_i, cyc: ibus_cyc_i};
  assign dreq = '{adr: dbus_adr_i, dat: dbus_dat_i, sel: dbus_sel_i, cti: dbus_cti_i,
                  bte: dbus_bte_i, we: dbus_we_i, stb: dbus_stb_i, cyc: dbus_cyc_i};

  // Mux keys only off the registered state, so IDLE never leaks a master's cyc to the slave.
  always_comb begin
    gnt_i   = (state_q == ARB_GNT_I);
    gnt_d   = (state_q == ARB_GNT_D);
    granted = gnt_i || gnt_d;
    greq    = WB_REQ_IDLE;
    if (gnt_i)      greq = ireq;
    else if (gnt_d) greq = dreq;
    term   = wbm_ack_i || wbm_err_i || wbm_rty_i;
    wd_en  = granted && greq.stb && !term;
    wd_clr = !wd_en;
  end

  eco32f_wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .fire_o(wd_fire)
  );

  always_comb begin
    wbm_adr_o  = greq.adr;
    wbm_dat_o  = greq.dat;
    wbm_sel_o  = greq.sel;
    wbm_cti_o  = greq.cti;
    wbm_bte_o  = greq.bte;
    wbm_we_o   = greq.we;
    wbm_cyc_o  = greq.cyc && !wd_fire;
    wbm_stb_o  = greq.stb && !wd_fire;
    ibus_ack_o = gnt_i && wbm_ack_i && !wd_fire;
    ibus_err_o = gnt_i && (wbm_err_i || wd_fire);
    ibus_rty_o = gnt_i && wbm_rty_i;
    dbus_ack_o = gnt_d && wbm_ack_i && !wd_fire;
    dbus_err_o = gnt_d && (wbm_err_i || wd_fire);
    dbus_rty_o = gnt_d && wbm_rty_i;
    ibus_dat_o = wbm_dat_i;
    dbus_dat_o = wbm_dat_i;
    timeout_o  = wd_fire;
  end

  // Release only on cyc drop or watchdog; IDLE always lasts one cycle between owners.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (state_q == ARB_IDLE) begin
      state_d = arb_pick(ibus_cyc_i, dbus_cyc_i, last_q);
    end else if (!granted) begin
      state_d = ARB_IDLE;
    end else if (!greq.cyc || wd_fire) begin
      state_d = ARB_IDLE;
      last_d  = gnt_d ? MST_D : MST_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= MST_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Directed + random bench for eco32f_wb_arbiter against a cycle-level ownership model.
module tb_eco32f_wb_arbiter;
  import eco32f_wb_arbiter_pkg::*;

  localparam int TO = 4;

  logic        clk, rst;
  logic [31:0] ibus_adr_i, ibus_dat_i, ibus_dat_o, dbus_adr_i, dbus_dat_i, dbus_dat_o;
  logic        ibus_stb_i, ibus_cyc_i, ibus_we_i, ibus_ack_o, ibus_err_o, ibus_rty_o;
  logic        dbus_stb_i, dbus_cyc_i, dbus_we_i, dbus_ack_o, dbus_err_o, dbus_rty_o;
  logic [3:0]  ibus_sel_i, dbus_sel_i, wbm_sel_o;
  logic [2:0]  ibus_cti_i, dbus_cti_i, wbm_cti_o;
  logic [1:0]  ibus_bte_i, dbus_bte_i, wbm_bte_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_ack_i, wbm_err_i, wbm_rty_i, timeout_o;

  eco32f_wb_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ibus_adr_i(ibus_adr_i), .ibus_stb_i(ibus_stb_i), .ibus_cyc_i(ibus_cyc_i),
    .ibus_we_i(ibus_we_i), .ibus_sel_i(ibus_sel_i), .ibus_cti_i(ibus_cti_i),
    .ibus_bte_i(ibus_bte_i), .ibus_dat_i(ibus_dat_i), .ibus_ack_o(ibus_ack_o),
    .ibus_err_o(ibus_err_o), .ibus_rty_o(ibus_rty_o), .ibus_dat_o(ibus_dat_o),
    .dbus_adr_i(dbus_adr_i), .dbus_stb_i(dbus_stb_i), .dbus_cyc_i(dbus_cyc_i),
    .dbus_we_i(dbus_we_i), .dbus_sel_i(dbus_sel_i), .dbus_cti_i(dbus_cti_i),
    .dbus_bte_i(dbus_bte_i), .dbus_dat_i(dbus_dat_i), .dbus_ack_o(dbus_ack_o),
    .dbus_err_o(dbus_err_o), .dbus_rty_o(dbus_rty_o), .dbus_dat_o(dbus_dat_o),
    .wbm_adr_o(wbm_adr_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (0 none, 1 ibus, 2 dbus), who owned it last,
  // and how many consecutive strobed cycles have gone unanswered.
  int m_own, m_last, m_stall;
  logic [8:0]  e_ctl;
  logic [9:0]  e_attr;
  logic [31:0] e_adr, e_wdat;
  logic [2:0]  e_trm_i, e_trm_d;
  logic        e_gc, e_gs, e_fire;

  // Random master agents (index 0 = ibus, 1 = dbus).
  int          a_act[2], a_beats[2], a_beat[2];
  logic [31:0] a_adr[2];
  logic        a_we[2];
  int          glog[$];
  logic [31:0] wrap_adr[8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [2:0] cti,
                       input logic [1:0] bte, input logic [31:0] dat);
    if (m == 0) begin
      ibus_cyc_i = c; ibus_stb_i = s; ibus_we_i = we; ibus_adr_i = adr;
      ibus_sel_i = sel; ibus_cti_i = cti; ibus_bte_i = bte; ibus_dat_i = dat;
    end else begin
      dbus_cyc_i = c; dbus_stb_i = s; dbus_we_i = we; dbus_adr_i = adr;
      dbus_sel_i = sel; dbus_cti_i = cti; dbus_bte_i = bte; dbus_dat_i = dat;
    end
  endtask

  task automatic set_s(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    wbm_ack_i = ack; wbm_err_i = err; wbm_rty_i = rty; wbm_dat_i = dat;
  endtask

  // Compute this cycle's expected outputs from the model, then check at the falling edge.
  task automatic cyc_begin();
    logic       gwe, resp_any;
    logic [3:0] gsel;
    logic [2:0] gcti, resp;
    logic [1:0] gbte;
    e_gc = 0; e_gs = 0; gwe = 0; gsel = 0; gcti = 0; gbte = 0; e_adr = 0; e_wdat = 0;
    if (m_own == 1) begin
      e_gc = ibus_cyc_i; e_gs = ibus_stb_i; gwe = ibus_we_i; gsel = ibus_sel_i;
      gcti = ibus_cti_i; gbte = ibus_bte_i; e_adr = ibus_adr_i; e_wdat = ibus_dat_i;
    end else if (m_own == 2) begin
      e_gc = dbus_cyc_i; e_gs = dbus_stb_i; gwe = dbus_we_i; gsel = dbus_sel_i;
      gcti = dbus_cti_i; gbte = dbus_bte_i; e_adr = dbus_adr_i; e_wdat = dbus_dat_i;
    end
    resp_any = wbm_ack_i || wbm_err_i || wbm_rty_i;
    e_fire   = (m_own != 0) && e_gs && !resp_any && (m_stall == TO - 1);
    resp     = {wbm_ack_i && !e_fire, wbm_err_i || e_fire, wbm_rty_i};
    e_trm_i  = (m_own == 1) ? resp : 3'b000;
    e_trm_d  = (m_own == 2) ? resp : 3'b000;
    e_ctl    = {e_gc && !e_fire, e_gs && !e_fire, e_trm_i, e_trm_d, e_fire};
    e_attr   = {gwe, gsel, gcti, gbte};
    @(negedge clk);
    chk("ctl", {wbm_cyc_o, wbm_stb_o, ibus_ack_o, ibus_err_o, ibus_rty_o,
                dbus_ack_o, dbus_err_o, dbus_rty_o, timeout_o}, e_ctl);
    if (m_own != 0) begin
      chk("attr", {wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o}, e_attr);
      chk("adr", wbm_adr_o, e_adr);
      chk("wdat", wbm_dat_o, e_wdat);
    end
    chk("rdat", {ibus_dat_o, dbus_dat_o}, {wbm_dat_i, wbm_dat_i});
    if (ibus_ack_o) glog.push_back(1);
    if (dbus_ack_o) glog.push_back(2);
  endtask

  task automatic cyc_end();
    if (rst) begin
      m_own = 0; m_last = 1; m_stall = 0;
    end else if (m_own == 0) begin
      m_stall = 0;
      if (ibus_cyc_i && dbus_cyc_i) m_own = (m_last == 1) ? 2 : 1;
      else if (ibus_cyc_i)          m_own = 1;
      else if (dbus_cyc_i)          m_own = 2;
    end else if (!e_gc || e_fire) begin
      m_last = m_own; m_own = 0; m_stall = 0;
    end else if (e_gs && !(wbm_ack_i || wbm_err_i || wbm_rty_i)) begin
      m_stall++;
    end else begin
      m_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  // Masters hold a transaction until terminated; bursts are 8-beat wraps.
  task automatic agents(input int start_pct, input int burst_pct, input int gap_pct);
    for (int m = 0; m < 2; m++) begin
      logic [2:0]  t;
      logic [31:0] adr;
      logic        stb;
      t = (m == 0) ? e_trm_i : e_trm_d;
      if (a_act[m] != 0) begin
        if (t != 3'b000) begin
          if (t[2] && (a_beat[m] < a_beats[m] - 1)) a_beat[m]++;
          else a_act[m] = 0;
        end
      end else if ($urandom_range(99) < start_pct) begin
        a_act[m]   = 1;
        a_beat[m]  = 0;
        a_beats[m] = ($urandom_range(99) < burst_pct) ? 8 : 1;
        a_adr[m]   = $urandom & 32'hffff_fffc;
        a_we[m]    = 1'($urandom_range(1));
      end
      stb = (a_act[m] != 0) && ($urandom_range(99) >= gap_pct);
      if (a_act[m] == 0)
        set_m(m, 0, 0, 0, 0, 0, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
      else if (a_beats[m] == 1)
        set_m(m, 1, stb, a_we[m], a_adr[m], 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, a_adr[m]);
      else begin
        adr = (a_adr[m] & 32'hffff_ffe0) | ((a_adr[m] + 32'(4 * a_beat[m])) & 32'h1c);
        set_m(m, 1, stb, a_we[m], adr, 4'hf,
              (a_beat[m] == 7) ? ECO32F_WB_CTI_EOB : ECO32F_WB_CTI_INCR,
              ECO32F_WB_BTE_WRAP8, adr ^ 32'h5a5a_0000);
      end
    end
  endtask

  task automatic slave(input int ack_pct, input int err_pct, input int rty_pct);
    logic gs;
    int   r;
    gs = (m_own == 1) ? ibus_stb_i : (m_own == 2) ? dbus_stb_i : 1'b0;
    r  = $urandom_range(99);
    set_s(0, 0, 0, $urandom);
    if (gs) begin
      if (r < ack_pct)                         wbm_ack_i = 1;
      else if (r < ack_pct + err_pct)          wbm_err_i = 1;
      else if (r < ack_pct + err_pct + rty_pct) wbm_rty_i = 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rst = 0;
    while ((a_act[0] != 0 || a_act[1] != 0) && n < 100) begin
      agents(0, 0, 0);
      slave(100, 0, 0);
      step();
      n++;
    end
    chk("drain_bound", 64'(n < 100), 64'(1));
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_s(0, 0, 0, 0);
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1);
  end

  initial begin
    wrap_adr = '{32'hE000_0014, 32'hE000_0018, 32'hE000_001C, 32'hE000_0000,
                 32'hE000_0004, 32'hE000_0008, 32'hE000_000C, 32'hE000_0010};
    a_act = '{0, 0};
    rst = 1;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_s(0, 0, 0, 0);
    @(posedge clk); #1;
    m_own = 0; m_last = 1; m_stall = 0;
    cyc_begin();
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_timeout", timeout_o, 0);
    cyc_end();
    rst = 0;
    step();

    // dbus single read, slave acks after two wait cycles.
    set_m(1, 1, 1, 0, 32'h0000_1000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
    cyc_begin(); chk("s1_arb_cycle_cyc", wbm_cyc_o, 0); cyc_end();
    cyc_begin(); chk("s1_grant_cyc", wbm_cyc_o, 1); chk("s1_adr", wbm_adr_o, 32'h0000_1000); cyc_end();
    step();
    set_s(1, 0, 0, 32'hDEAD_BEEF);
    cyc_begin();
    chk("s1_ack", dbus_ack_o, 1); chk("s1_dat", dbus_dat_o, 32'hDEAD_BEEF);
    chk("s1_ibus_ack", ibus_ack_o, 0);
    cyc_end();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step();
    cyc_begin(); chk("s1_idle_cyc", wbm_cyc_o, 0); cyc_end();

    // Simultaneous request straight after reset: dbus first, then one IDLE, then ibus.
    rst = 1; step(); rst = 0;
    set_m(0, 1, 1, 0, 32'h0000_3000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
    set_m(1, 1, 1, 1, 32'h0000_4000, 4'h3, ECO32F_WB_CTI_CLASSIC, 2'b00, 32'h1111_2222);
    step();
    set_s(1, 0, 0, 0);
    cyc_begin();
    chk("s2_first_dbus", wbm_adr_o, 32'h0000_4000); chk("s2_dack", dbus_ack_o, 1);
    chk("s2_no_iack", ibus_ack_o, 0);
    cyc_end();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step();
    cyc_begin(); chk("s2_idle_gap", wbm_cyc_o, 0); cyc_end();
    set_s(1, 0, 0, 0);
    cyc_begin(); chk("s2_then_ibus", wbm_adr_o, 32'h0000_3000); chk("s2_iack", ibus_ack_o, 1); cyc_end();
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step(); step();

    // Round robin with both masters re-requesting back to back.
    glog.delete();
    for (int k = 0; k < 12; k++) begin
      agents(100, 0, 0);
      slave(100, 0, 0);
      step();
    end
    chk("rr_count", 64'(glog.size() >= 4), 64'(1));
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk("rr_order", 64'(glog[k]), 64'((k % 2 == 0) ? 2 : 1));
    drain();

    // ibus 8-beat wrap refill; dbus requests at beat 2 and must wait for the whole burst.
    set_m(0, 1, 1, 0, wrap_adr[0], 4'hf, ECO32F_WB_CTI_INCR, ECO32F_WB_BTE_WRAP8, 0);
    step();
    for (int b = 0; b < 8; b++) begin
      set_m(0, 1, 1, 0, wrap_adr[b], 4'hf,
            (b == 7) ? ECO32F_WB_CTI_EOB : ECO32F_WB_CTI_INCR, ECO32F_WB_BTE_WRAP8, 0);
      if (b == 1) set_m(1, 1, 1, 1, 32'h0000_5000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 32'hCAFE_0000);
      set_s(1, 0, 0, 32'h1000_0000 + 32'(b));
      cyc_begin();
      chk("burst_adr", wbm_adr_o, wrap_adr[b]); chk("burst_iack", ibus_ack_o, 1);
      chk("burst_no_dack", dbus_ack_o, 0);
      cyc_end();
    end
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step();
    step();
    set_s(1, 0, 0, 0);
    cyc_begin(); chk("burst_then_dbus", wbm_adr_o, 32'h0000_5000); chk("burst_dack", dbus_ack_o, 1); cyc_end();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step(); step();

    // Dead slave: fourth stalled cycle becomes a forced error.
    set_m(1, 1, 1, 0, 32'h0000_2000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
    step();
    for (int k = 0; k < TO - 1; k++) begin
      cyc_begin(); chk("wd_stall_err", dbus_err_o, 0); chk("wd_stall_cyc", wbm_cyc_o, 1); cyc_end();
    end
    cyc_begin();
    chk("wd_err", dbus_err_o, 1); chk("wd_pulse", timeout_o, 1);
    chk("wd_cyc", wbm_cyc_o, 0); chk("wd_no_ack", dbus_ack_o, 0);
    cyc_end();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc_begin(); chk("wd_pulse_once", timeout_o, 0); cyc_end();
    set_m(0, 1, 1, 0, 32'h0000_6000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
    step();
    set_s(1, 0, 0, 32'h0BAD_F00D);
    cyc_begin(); chk("wd_next_grant", ibus_ack_o, 1); cyc_end();
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step(); step();

    // Ack on the would-be timeout cycle wins.
    set_m(1, 1, 1, 0, 32'h0000_7000, 4'hf, ECO32F_WB_CTI_CLASSIC, 2'b00, 0);
    step();
    for (int k = 0; k < TO - 1; k++) step();
    set_s(1, 0, 0, 32'h1234_5678);
    cyc_begin();
    chk("late_ack", dbus_ack_o, 1); chk("late_no_err", dbus_err_o, 0);
    chk("late_no_timeout", timeout_o, 0); chk("late_dat", dbus_dat_o, 32'h1234_5678);
    cyc_end();
    set_m(1, 0, 0, 0, 0, 0, 0, 0, 0); set_s(0, 0, 0, 0);
    step(); step();

    // Reset in the middle of a burst.
    set_m(0, 1, 1, 0, wrap_adr[0], 4'hf, ECO32F_WB_CTI_INCR, ECO32F_WB_BTE_WRAP8, 0);
    step();
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1, 1, 0, wrap_adr[b], 4'hf, ECO32F_WB_CTI_INCR, ECO32F_WB_BTE_WRAP8, 0);
      set_s(1, 0, 0, 0);
      step();
    end
    set_m(0, 1, 1, 0, wrap_adr[3], 4'hf, ECO32F_WB_CTI_INCR, ECO32F_WB_BTE_WRAP8, 0);
    set_s(0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    cyc_begin(); chk("rst_mid_cyc", wbm_cyc_o, 0); chk("rst_mid_stb", wbm_stb_o, 0); cyc_end();
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Random traffic with normal, slow and dead slave phases.
    a_act = '{0, 0};
    for (int i = 0; i < 900; i++) begin
      rst = ($urandom_range(299) == 0);
      agents(35, 40, 10);
      case ((i / 100) % 3)
        0:       slave(50, 5, 5);
        1:       slave(15, 2, 2);
        default: slave(0, 0, 0);
      endcase
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
